calc_dispatcher: RTL
====================

# calc_dispatcher

Sequencing front-end for the matrix calculator core. Accepts one operation request from the UI FSM, latches and validates operand descriptors, and checks operation code, dimension range, dimension compatibility and result address range. A valid request gets a one-cycle start pulse to the core, with operands held stable, and the block waits for completion. An invalid request gets a latched error code that the UI clears with an acknowledge.

## Interface
- MAX_DIM, 5: largest legal row/column count.
- TIMEOUT_CYCLES, 4096: watchdog limit in WAIT; used only with the timeout feature enabled.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_op_code  in  3  operation: 0 transpose, 1 add, 2 scalar multiply, 3 multiply, 4–7 illegal.
- i_op1_addr, i_op2_addr, i_res_addr  in  8 each  storage base addresses.
- i_op1_m, i_op1_n, i_op2_m, i_op2_n  in  32 each  dimensions; i_op2_m is the scalar for op 2.
- o_ready  out  1  high in IDLE.
- o_busy  out  1  high in CHECK, START and WAIT.
- o_start_calc  out  1  one-cycle start pulse to the core.
- o_op_code, o_op*_addr, o_res_addr, o_op*_m/n  out  same widths as inputs  latched copies, driven to the core.
- i_calc_done  in  1  core completion pulse.
- o_res_m, o_res_n  out  32 each  result dimensions.
- o_done  out  1  one-cycle success pulse.
- o_err  out  1  error flag, held until acknowledged.
- o_err_code  out  3  error code: 0 none, 1 illegal op, 2 dimension out of range, 3 dimension mismatch, 4 result address overflow, 5 timeout.
- i_err_ack  in  1  clears the error.
- o_op_count  out  16  count of successful operations; wraps at 16 bits.

## Operation
- States and transitions:
  - IDLE: on i_req, latch all operand inputs, go to CHECK.
  - CHECK: always one cycle; go to ERR if any check fails, else START.
  - START: drive o_start_calc for one cycle, clear the timer, go to WAIT.
  - WAIT: on i_calc_done, go to DONE.
  - DONE: drive o_done, increment o_op_count, latch o_res_m/o_res_n, go to IDLE.
  - ERR: on i_err_ack, go to IDLE.
- Checks, in priority order; report only the first failing check:
  - Illegal op: op code ≥ 4.
  - Range: each used dimension must satisfy 1 ≤ d ≤ MAX_DIM.
    - Ops 0 and 2 use m1 and n1. The op 2 scalar is unrestricted.
    - Ops 1 and 3 use m1, n1, m2 and n2.
  - Mismatch: op 1 needs m1==m2 and n1==n2; op 3 needs n1==m2.
  - Address: res_addr + res_m*res_n − 1 > 255, evaluated in 9+ bits.
- Result dimensions: op 0 gives (n1, m1); ops 1 and 2 give (m1, n1); op 3 gives (m1, n2).
- Operand outputs change only on the IDLE→CHECK edge. They stay stable from START through WAIT, because the core reads them continuously.
- i_req outside IDLE is dropped; there is no queueing.
- i_calc_done outside WAIT is ignored, including a late done after a timeout.
- In ERR, simultaneous i_err_ack and i_req: the acknowledge is taken and the request is dropped.
- In WAIT, i_calc_done and timer expiry in the same cycle: done wins.
- Reset values:
  - All outputs 0, except o_ready=1; state IDLE.
  - Reset mid-operation aborts to IDLE. The core shares rst_n.

## Timing
- i_req sampled at edge T: CHECK in cycle T+1. Then either o_start_calc high in cycle T+2, or o_err/o_err_code valid from cycle T+2.
- i_calc_done sampled at edge D: o_done high in cycle D+1 only; o_op_count and o_res_* updated at the same edge.
- i_err_ack sampled at edge A: o_err low and o_ready high from cycle A+1.
- Timeout: WAIT entered at edge W with no done; ERR with code 5 from edge W+TIMEOUT_CYCLES.
- Minimum request-to-request spacing is 4 cycles plus the core latency.

## Configuration
- CALC_TIMEOUT_EN defined:
  - Watchdog counter of $clog2(TIMEOUT_CYCLES+1) bits is active in WAIT.
  - Error code 5 is possible.
- Not defined:
  - No counter is instantiated.
  - WAIT exits only on i_calc_done.
  - Error code 5 is never produced.

## Structure
- Shared package calc_pkg holds:
  - op code constants: OP_TRANSPOSE, OP_ADD, OP_SCALAR, OP_MUL;
  - error code constants: ERR_NONE … ERR_TIMEOUT;
  - the dispatcher state encoding.
- One combinational sub-module, calc_operand_check:
  - inputs: latched operands;
  - outputs: error code, res_m, res_n.
- The dispatcher registers the sub-module's outputs at the end of CHECK.

## Test plan
- op 3, m1=2, n1=3, m2=3, n2=2, res_addr=0x40, i_calc_done 20 cycles after start:
  - o_start_calc exactly 1 cycle at T+2;
  - o_done at done+1;
  - o_res=2×2, o_op_count=1.
- op 1, 2×3 plus 3×2 → o_err=1, code 3, no start pulse; i_err_ack → o_ready next cycle.
- op 0 with m1=6 → code 2. op 5 with m1=6 → code 1, since priority applies.
- op 2, 5×5, res_addr=0xF0 → code 4. Same with res_addr=0xE7 → accepted, since 0xE7+24=0xFF.
- CALC_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done:
  - code 5 at W+16;
  - a later i_calc_done is ignored and o_op_count is unchanged.
- Assert rst_n in WAIT:
  - outputs return to reset values, o_ready=1;
  - a subsequent legal request completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the matrix calculator front-end: op codes, error codes
// and the dispatcher state encoding.
package calc_pkg;

  localparam logic [2:0] OP_TRANSPOSE = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_SCALAR    = 3'd2;
  localparam logic [2:0] OP_MUL       = 3'd3;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL_OP = 3'd1;
  localparam logic [2:0] ERR_RANGE      = 3'd2;
  localparam logic [2:0] ERR_MISMATCH   = 3'd3;
  localparam logic [2:0] ERR_ADDR       = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/calc_operand_check.sv
// Combinational validation of latched operand descriptors; yields the first
// failing check's error code and the result matrix dimensions.
module calc_operand_check
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIM = 5
) (
  input  logic [2:0]  op_code_i,
  input  logic [7:0]  res_addr_i,
  input  logic [31:0] op1_m_i,
  input  logic [31:0] op1_n_i,
  input  logic [31:0] op2_m_i,
  input  logic [31:0] op2_n_i,
  output logic [2:0]  err_code_o,
  output logic [31:0] res_m_o,
  output logic [31:0] res_n_o
);

  function automatic logic dim_ok(input logic [31:0] d);
    return (d >= 32'd1) && (d <= 32'(MAX_DIM));
  endfunction

  logic        uses_op2;
  logic        dims_ok;
  logic        mismatch;
  logic [15:0] area;
  logic [16:0] addr_end;

  always_comb begin
    res_m_o  = op1_m_i;
    res_n_o  = op1_n_i;
    mismatch = 1'b0;
    uses_op2 = (op_code_i == OP_ADD) || (op_code_i == OP_MUL);
    dims_ok  = dim_ok(op1_m_i) && dim_ok(op1_n_i) &&
               (!uses_op2 || (dim_ok(op2_m_i) && dim_ok(op2_n_i)));
    case (op_code_i)
      OP_TRANSPOSE: begin
        res_m_o = op1_n_i;
        res_n_o = op1_m_i;
      end
      OP_ADD:  mismatch = (op1_m_i != op2_m_i) || (op1_n_i != op2_n_i);
      OP_MUL: begin
        mismatch = (op1_n_i != op2_m_i);
        res_n_o  = op2_n_i;
      end
      default: ;
    endcase
    // Only consulted once the range check passed, so the low byte holds the full dimension.
    area     = res_m_o[7:0] * res_n_o[7:0];
    addr_end = 17'(res_addr_i) + 17'(area);
    err_code_o = ERR_NONE;
    if (op_code_i[2])
      err_code_o = ERR_ILLEGAL_OP;
    else if (!dims_ok)
      err_code_o = ERR_RANGE;
    else if (mismatch)
      err_code_o = ERR_MISMATCH;
    else if (addr_end > 17'd256)
      err_code_o = ERR_ADDR;
  end

endmodule

// File: rtl/calc_dispatcher.sv
// Request sequencer for the matrix core: latch, validate, start, await done.
// Optional watchdog in WAIT enabled by defining CALC_TIMEOUT_EN.
module calc_dispatcher
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIM        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [2:0]  i_op_code,
  input  logic [7:0]  i_op1_addr,
  input  logic [7:0]  i_op2_addr,
  input  logic [7:0]  i_res_addr,
  input  logic [31:0] i_op1_m,
  input  logic [31:0] i_op1_n,
  input  logic [31:0] i_op2_m,
  input  logic [31:0] i_op2_n,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_start_calc,
  output logic [2:0]  o_op_code,
  output logic [7:0]  o_op1_addr,
  output logic [7:0]  o_op2_addr,
  output logic [7:0]  o_res_addr,
  output logic [31:0] o_op1_m,
  output logic [31:0] o_op1_n,
  output logic [31:0] o_op2_m,
  output logic [31:0] o_op2_n,
  input  logic        i_calc_done,
  output logic [31:0] o_res_m,
  output logic [31:0] o_res_n,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  input  logic        i_err_ack,
  output logic [15:0] o_op_count
);

  state_e      state_q, state_d;
  logic [2:0]  op_code_q;
  logic [7:0]  op1_addr_q, op2_addr_q, res_addr_q;
  logic [31:0] op1_m_q, op1_n_q, op2_m_q, op2_n_q;
  logic [31:0] chk_res_m_q, chk_res_n_q;
  logic [31:0] res_m_q, res_n_q;
  logic [2:0]  err_code_q;
  logic [15:0] op_count_q;
  logic [2:0]  chk_err;
  logic [31:0] chk_res_m, chk_res_n;
  logic        timeout_hit;

  calc_operand_check #(.MAX_DIM(MAX_DIM)) u_check (
    .op_code_i  (op_code_q),
    .res_addr_i (res_addr_q),
    .op1_m_i    (op1_m_q),
    .op1_n_i    (op1_n_q),
    .op2_m_i    (op2_m_q),
    .op2_n_i    (op2_n_q),
    .err_code_o (chk_err),
    .res_m_o    (chk_res_m),
    .res_n_o    (chk_res_n)
  );

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer_q <= '0;
    else if (state_q == ST_START)
      timer_q <= '0;
    else if (state_q == ST_WAIT)
      timer_q <= timer_q + 1'b1;
  end

  assign timeout_hit = (state_q == ST_WAIT) && !i_calc_done && (timer_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_req) state_d = ST_CHECK;
      ST_CHECK: state_d = (chk_err != ERR_NONE) ? ST_ERR : ST_START;
      ST_START: state_d = ST_WAIT;
      // A done in the expiry cycle takes precedence over the watchdog.
      ST_WAIT: begin
        if (i_calc_done)      state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   if (i_err_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_code_q   <= '0;
      op1_addr_q  <= '0;
      op2_addr_q  <= '0;
      res_addr_q  <= '0;
      op1_m_q     <= '0;
      op1_n_q     <= '0;
      op2_m_q     <= '0;
      op2_n_q     <= '0;
      chk_res_m_q <= '0;
      chk_res_n_q <= '0;
      res_m_q     <= '0;
      res_n_q     <= '0;
      err_code_q  <= ERR_NONE;
      op_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_req) begin
        op_code_q  <= i_op_code;
        op1_addr_q <= i_op1_addr;
        op2_addr_q <= i_op2_addr;
        res_addr_q <= i_res_addr;
        op1_m_q    <= i_op1_m;
        op1_n_q    <= i_op1_n;
        op2_m_q    <= i_op2_m;
        op2_n_q    <= i_op2_n;
      end
      if (state_q == ST_CHECK) begin
        chk_res_m_q <= chk_res_m;
        chk_res_n_q <= chk_res_n;
        err_code_q  <= chk_err;
      end
      // Count and result become visible together with the o_done pulse.
      if (state_q == ST_WAIT && i_calc_done) begin
        op_count_q <= op_count_q + 16'd1;
        res_m_q    <= chk_res_m_q;
        res_n_q    <= chk_res_n_q;
      end
`ifdef CALC_TIMEOUT_EN
      if (timeout_hit)
        err_code_q <= ERR_TIMEOUT;
`endif
      if (state_q == ST_ERR && i_err_ack)
        err_code_q <= ERR_NONE;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_busy       = (state_q == ST_CHECK) || (state_q == ST_START) || (state_q == ST_WAIT);
  assign o_start_calc = (state_q == ST_START);
  assign o_done       = (state_q == ST_DONE);
  assign o_err        = (state_q == ST_ERR);
  assign o_err_code   = err_code_q;
  assign o_op_count   = op_count_q;
  assign o_res_m      = res_m_q;
  assign o_res_n      = res_n_q;
  assign o_op_code    = op_code_q;
  assign o_op1_addr   = op1_addr_q;
  assign o_op2_addr   = op2_addr_q;
  assign o_res_addr   = res_addr_q;
  assign o_op1_m      = op1_m_q;
  assign o_op1_n      = op1_n_q;
  assign o_op2_m      = op2_m_q;
  assign o_op2_n      = op2_n_q;

endmodule
